// File: rtl/arith_seq_pkg.sv
// Shared definitions for the sequential arithmetic unit.
//   op_e     : command op-codes carried on cmd_op
//   state_e  : FSM states of arith_seq_unit
//   OPC_*    : raw op-code constants for code that works on plain vectors
package arith_seq_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_SHL = 3'd4,
    OP_SHR = 3'd5,
    OP_MUL = 3'd6,
    OP_DIV = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [OP_W-1:0] OPC_ADD = 3'd0;
  localparam logic [OP_W-1:0] OPC_SUB = 3'd1;
  localparam logic [OP_W-1:0] OPC_AND = 3'd2;
  localparam logic [OP_W-1:0] OPC_XOR = 3'd3;
  localparam logic [OP_W-1:0] OPC_SHL = 3'd4;
  localparam logic [OP_W-1:0] OPC_SHR = 3'd5;
  localparam logic [OP_W-1:0] OPC_MUL = 3'd6;
  localparam logic [OP_W-1:0] OPC_DIV = 3'd7;

endpackage

// File: rtl/arith_iter_step.sv
// One combinational iteration of the multi-cycle operations.
//   is_div : 1 = restoring-divide step, 0 = shift-add multiply step
//   m      : multiplicand (MUL) or divisor (DIV)
//   hi, lo : current partial result (high / low word)
//   hi_nxt, lo_nxt : partial result after this step
// MUL: {hi,lo} holds {partial product, remaining multiplier}; add m when the
//      multiplier LSB is set, then shift the whole pair right by one.
// DIV: {hi,lo} holds {remainder, remaining dividend/quotient}; shift left,
//      trial-subtract m, keep the difference when it did not borrow.
// Divide path only present when ARITH_SEQ_DIV_EN is defined.
module arith_iter_step
  #(parameter int WIDTH = 30)
  (
    input  logic             is_div,
    input  logic [WIDTH-1:0] m,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
  );

  logic [WIDTH:0] add_sum;

  assign add_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});

`ifdef ARITH_SEQ_DIV_EN
  logic [WIDTH:0]   shl_rem;
  logic [WIDTH+1:0] trial;
  logic             borrow;
  logic             unused_bits;

  assign shl_rem = {hi, lo[WIDTH-1]};
  assign trial   = {1'b0, shl_rem} - {2'b00, m};
  assign borrow  = trial[WIDTH+1];
  // The remainder always stays below m, so these top bits carry no information
  // once the borrow has been decided.
  assign unused_bits = trial[WIDTH] ^ shl_rem[WIDTH];

  always_comb begin
    hi_nxt = add_sum[WIDTH:1];
    lo_nxt = {add_sum[0], lo[WIDTH-1:1]};
    if (is_div) begin
      hi_nxt = borrow ? shl_rem[WIDTH-1:0] : trial[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], ~borrow};
    end
  end
`else
  logic unused_is_div;
  assign unused_is_div = is_div;

  always_comb begin
    hi_nxt = add_sum[WIDTH:1];
    lo_nxt = {add_sum[0], lo[WIDTH-1:1]};
  end
`endif

endmodule

// File: rtl/arith_seq_unit.sv
// Sequential arithmetic unit: single-cycle ALU ops plus multi-cycle MUL/DIV.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_op, opa, opb are the command
//   res_valid/res_ready    result handshake; res_lo (C reg), res_hi (B reg),
//                          res_carry, res_err are the result
//   dbg_state              current FSM state (state_e encoding)
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high; a producer holds its payload stable while valid is high and ready low.
// Config: define ARITH_SEQ_DIV_EN to build the restoring divider; otherwise
// op DIV completes in one cycle with res_err=1 and zero results.
// Multi-cycle ops spend one ITER cycle moving operands into place, then WIDTH
// step cycles, so the result appears WIDTH+1 cycles after accept.
module arith_seq_unit
  import arith_seq_pkg::*;
  #(
    parameter int WIDTH = 30,
    parameter int CNT_W = $clog2(WIDTH+1)
  )
  (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             res_carry,
    output logic             res_err,
    output logic [1:0]       dbg_state
  );

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic             carry_q, carry_d, err_q, err_d, prep_q, prep_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic [WIDTH:0]   add_ext, sub_ext;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             step_is_div;

  assign accept      = cmd_valid && (state_q == ST_IDLE);
  assign add_ext     = {1'b0, a_q} + {1'b0, b_q};
  assign sub_ext     = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
  assign step_is_div = (op_q == OP_DIV);

  arith_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div (step_is_div),
    .m      (a_q),
    .hi     (b_q),
    .lo     (c_q),
    .hi_nxt (step_hi),
    .lo_nxt (step_lo)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_MUL: state_d = ST_ITER;
`ifdef ARITH_SEQ_DIV_EN
            OP_DIV: state_d = (opb == '0) ? ST_EXEC : ST_ITER;
`endif
            default: state_d = ST_EXEC;
          endcase
        end
      end
      ST_EXEC: state_d = ST_DONE;
      ST_ITER: if (!prep_q && (cnt_q == '0)) state_d = ST_DONE;
      ST_DONE: if (res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    res_valid = (state_q == ST_DONE);
    dbg_state = state_q;
  end

  assign res_lo    = c_q;
  assign res_hi    = b_q;
  assign res_carry = carry_q;
  assign res_err   = err_q;

  // Datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      prep_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      prep_q  <= prep_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath next values
  always_comb begin
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    carry_d = carry_q;
    err_d   = err_q;
    prep_d  = prep_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = op_e'(cmd_op);
          a_d     = opa;
          b_d     = opb;
          carry_d = 1'b0;
          err_d   = 1'b0;
          prep_d  = 1'b1;
        end
      end
      ST_EXEC: begin
        b_d = '0;
        case (op_q)
          OP_ADD: {carry_d, c_d} = add_ext;
          OP_SUB: {carry_d, c_d} = sub_ext;  // carry = no borrow
          OP_AND: c_d = a_q & b_q;
          OP_XOR: c_d = a_q ^ b_q;
          OP_SHL: begin
            c_d     = {a_q[WIDTH-2:0], 1'b0};
            carry_d = a_q[WIDTH-1];
          end
          OP_SHR: begin
            c_d     = {1'b0, a_q[WIDTH-1:1]};
            carry_d = a_q[0];
          end
          OP_DIV: begin
            // Only reached for divide-by-zero, or when no divider is built.
            err_d = 1'b1;
`ifdef ARITH_SEQ_DIV_EN
            c_d = '1;
            b_d = a_q;
`else
            c_d = '0;
`endif
          end
          default: ;
        endcase
      end
      ST_ITER: begin
        if (prep_q) begin
          // Arrange operands: hi (B) = 0, lo (C) = multiplier or dividend,
          // A = multiplicand or divisor.
          prep_d = 1'b0;
          cnt_d  = CNT_W'(WIDTH-1);
          b_d    = '0;
`ifdef ARITH_SEQ_DIV_EN
          if (op_q == OP_DIV) begin
            c_d = a_q;
            a_d = b_q;
          end else begin
            c_d = b_q;
          end
`else
          c_d = b_q;
`endif
        end else begin
          b_d = step_hi;
          c_d = step_lo;
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/arith_seq_unit.md
ARITH_SEQ_UNIT -- requirements
Module: arith_seq_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 30: operand/result width in bits; legal range 4..64.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1): iteration counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  unit can accept a command.
REQ-007 SHALL have port cmd_op  input  3  operation: 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 SHL, 5 SHR, 6 MUL, 7 DIV.
REQ-008 SHALL have ports opa, opb  input  WIDTH  unsigned operands.
REQ-009 SHALL have port res_valid  output  1  result available.
REQ-010 SHALL have port res_ready  input  1  consumer takes result.
REQ-011 SHALL have ports res_lo, res_hi  output  WIDTH  result low and high words (C and B registers).
REQ-012 SHALL have ports res_carry, res_err  output  1  carry/no-borrow/shift-out bit, and error flag.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, ITER, DONE; cmd_ready = (state == IDLE).
REQ-014 SHALL accept a command on any edge with cmd_valid & cmd_ready, capturing cmd_op, opa into A, and opb into B.
REQ-015 For ops 0-5, SHALL go IDLE->EXEC->DONE, with res_valid high one cycle after accept.
REQ-016 ADD SHALL give {res_carry,res_lo}=opa+opb; SUB SHALL give opa+~opb+1 with res_carry=1 meaning no borrow; AND/XOR SHALL be bitwise; for ops 0-5 res_hi SHALL be 0.
REQ-017 SHL/SHR SHALL shift opa one bit and zero-fill; res_carry SHALL hold the bit shifted out.
REQ-018 MUL SHALL go IDLE->ITER, run WIDTH shift-add iterations, then go to DONE; res_valid SHALL assert WIDTH+1 cycles after accept; {res_hi,res_lo} SHALL equal the full 2*WIDTH-bit unsigned product.
REQ-019 DIV SHALL run WIDTH restoring iterations with identical timing; res_lo SHALL be the quotient and res_hi the remainder.
REQ-020 DIV with opb==0 SHALL skip ITER, go to DONE after one cycle, and set res_err=1, res_lo=all ones, res_hi=opa.
REQ-021 Counter SHALL count WIDTH-1 down to 0; ITER SHALL exit when it reaches 0, with no wrap.
REQ-022 In DONE, outputs SHALL hold stable until res_valid & res_ready; the unit SHALL then return to IDLE; a new command is accepted no earlier than the next cycle (one bubble).
REQ-023 cmd_valid during EXEC/ITER/DONE SHALL be ignored with no side effects.
REQ-024 res_err and res_carry SHALL clear on each accepted command.

Reset
REQ-025 resetn low SHALL immediately force state=IDLE, res_valid=0, res_lo=0, res_hi=0, res_carry=0, res_err=0, counter=0; cmd_ready SHALL then read 1.
REQ-026 Reset during ITER SHALL abort the operation with no partial result visible; the first command SHALL be accepted on the first edge after resetn rises.

Configuration
REQ-027 Macro ARITH_SEQ_DIV_EN defined SHALL compile in the divide datapath per REQ-019/020.
REQ-028 Without ARITH_SEQ_DIV_EN, op 7 SHALL complete in one cycle with res_err=1, res_lo=0, res_hi=0, and no divide logic synthesised.

Structure
REQ-029 Package arith_seq_pkg SHALL hold the op-code enum, the FSM state enum, and op-code constants.
REQ-030 Sub-module arith_iter_step SHALL hold one combinational shift-add or shift-subtract step; it is instantiated once in arith_seq_unit.

Verification (WIDTH=30)
REQ-031 ADD 0x3FFFFFFF+0x00000001 -> res_lo=0, res_carry=1, res_valid one cycle after accept.
REQ-032 MUL 0x3FFFFFFF*0x3FFFFFFF -> res_hi=0x3FFFFFFE, res_lo=0x00000001, res_valid 31 cycles after accept.
REQ-033 DIV 100/7 -> res_lo=14, res_hi=2, res_err=0; DIV 5/0 -> res_err=1, res_lo=0x3FFFFFFF, res_hi=5 after one cycle.
REQ-034 resetn low during MUL iteration 10 -> all outputs 0, cmd_ready=1; a SUB 5-7 accepted right after release -> res_lo=0x3FFFFFFE, res_carry=0.
REQ-035 res_ready low for 5 cycles in DONE -> outputs stable, cmd_ready=0, extra cmd_valid ignored; then handshake -> IDLE.
REQ-036 Build without ARITH_SEQ_DIV_EN, DIV 100/7 -> res_err=1, res_lo=0, res_hi=0 after one cycle.
